// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_ctrl_pkg;

  typedef logic [31:0] Reg_t;
  typedef logic [63:0] DoubleReg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    DIVON   = 2'd2,
    DIVEND  = 2'd3
  } DivState_t;

  typedef logic [5:0] DivCnt_t;

  localparam DivCnt_t DIV_STEPS = 6'd32;

endpackage

// File: rtl/div_step.sv
// One restoring step: shift the next dividend bit into a 33-bit partial
// remainder, subtract the divisor when it fits, and shift in the quotient bit.
module div_step
  import div_ctrl_pkg::*;
(
  input  Reg_t rem,
  input  Reg_t quo,
  input  Reg_t divisor,
  output Reg_t rem_nxt,
  output Reg_t quo_nxt
);

  logic [32:0] pr;
  logic [32:0] diff;

  assign pr   = {rem, quo[31]};
  // Borrow out of the subtract means the divisor did not fit this step.
  assign diff = pr - {1'b0, divisor};

  assign rem_nxt = diff[32] ? pr[31:0] : diff[31:0];
  assign quo_nxt = {quo[30:0], ~diff[32]};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned 32-bit divider controller (IDLE/DIVZERO/DIVON/DIVEND).
// Define DIV_ZERO_FASTPATH_EN to short-circuit a zero divisor to a zero result.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  DivState_t  state, state_n;
  DivCnt_t    cnt, cnt_n;
  Reg_t       rem, rem_n, quo, quo_n, dvs, dvs_n;
  logic       neg_q, neg_q_n, neg_r, neg_r_n;
  DoubleReg_t result, result_n;
  logic       ready, ready_n, busy;

  Reg_t mag1, mag2, step_rem, step_quo, rem_fix, quo_fix;

  assign mag1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

  assign rem_fix = neg_r ? -rem : rem;
  assign quo_fix = neg_q ? -quo : quo;

  div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    quo_n    = quo;
    dvs_n    = dvs;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    result_n = result;
    ready_n  = ready;
    if (state != IDLE && annul_i) begin
      state_n  = IDLE;
      result_n = '0;
      ready_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            rem_n   = '0;
            quo_n   = mag1;
            dvs_n   = mag2;
            neg_q_n = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_r_n = signed_div_i && opdata1_i[31];
            cnt_n   = '0;
`ifdef DIV_ZERO_FASTPATH_EN
            state_n = (opdata2_i == '0) ? DIVZERO : DIVON;
`else
            state_n = DIVON;
`endif
          end
        end
        DIVZERO: begin
`ifdef DIV_ZERO_FASTPATH_EN
          state_n  = DIVEND;
          result_n = '0;
          ready_n  = 1'b1;
`else
          state_n  = IDLE;
`endif
        end
        DIVON: begin
          if (cnt != DIV_STEPS) begin
            rem_n = step_rem;
            quo_n = step_quo;
            cnt_n = cnt + DivCnt_t'(1);
          end else begin
            // All 32 steps done: this edge spends one cycle on sign correction.
            result_n = {rem_fix, quo_fix};
            ready_n  = 1'b1;
            state_n  = DIVEND;
          end
        end
        DIVEND: begin
          if (!start_i) begin
            state_n  = IDLE;
            result_n = '0;
            ready_n  = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rem    <= rem_n;
      quo    <= quo_n;
      dvs    <= dvs_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
      result <= result_n;
      ready  <= ready_n;
      busy   <= (state_n != IDLE);
    end
  end

  assign result_o = result;
  assign ready_o  = ready;
  assign busy_o   = busy;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the operand width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low (asserted at 0).
REQ-004 SHALL have port start_i, input, 1, the division request from the execute stage.
REQ-005 SHALL have port annul_i, input, 1, which cancels the request or operation in flight.
REQ-006 SHALL have port signed_div_i, input, 1; 1 selects signed, 0 selects unsigned.
REQ-007 SHALL have port opdata1_i, input, 32, the dividend.
REQ-008 SHALL have port opdata2_i, input, 32, the divisor.
REQ-009 SHALL have port result_o, output, 64, carrying {remainder[63:32] to HI, quotient[31:0] to LO}.
REQ-010 SHALL have port ready_o, output, 1, asserted while result_o is valid.
REQ-011 SHALL have port busy_o, output, 1, asserted in every state other than IDLE.

Function
REQ-012 SHALL implement an FSM with four states: IDLE, DIVZERO, DIVON, DIVEND.
REQ-013 IDLE: on start_i=1 and annul_i=0, SHALL latch the operands and signed_div_i, then go to DIVZERO if opdata2_i==0, else to DIVON with cnt=0.
REQ-014 Operand latch: in signed mode, a negative operand SHALL be latched as its two's-complement magnitude; original signs are kept for correction.
REQ-015 DIVON: one restoring step per cycle while cnt<32, then cnt+1; when cnt==32, SHALL apply sign correction, register result_o, and go to DIVEND.
REQ-016 Sign correction: quotient SHALL be negated when signed and the operand signs differ; remainder SHALL take the dividend's sign; unsigned results are uncorrected.
REQ-017 Latency: the start-accepting edge is edge 1, so ready_o SHALL rise after edge 34 (32 steps plus correction); busy_o SHALL rise after edge 1.
REQ-018 DIVEND: ready_o=1 and result_o SHALL hold stable while start_i=1; when start_i=0, SHALL go to IDLE on the next edge with ready_o=0 and result_o=0.
REQ-019 annul_i=1 in DIVZERO, DIVON or DIVEND SHALL force IDLE on the next edge with result_o=0 and ready_o=0; annul_i takes priority over all other transitions.
REQ-020 start_i changes while busy SHALL be ignored, except that start_i=0 in DIVEND triggers the DIVEND exit.
REQ-021 Operand changes after acceptance SHALL NOT affect the result.
REQ-022 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0, with no error indication.
REQ-023 ready_o and busy_o SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-024 While rst=0, state SHALL be IDLE, cnt=0, result_o=0, ready_o=0, busy_o=0, and all operand latches SHALL be 0.
REQ-025 Reset mid-operation SHALL discard the operation; the first start_i after deassertion SHALL be accepted normally.

Configuration
REQ-026 With DIV_ZERO_FASTPATH_EN defined, DIVZERO SHALL go to DIVEND on the next edge with result_o=0, so ready_o rises after edge 2.
REQ-027 With DIV_ZERO_FASTPATH_EN undefined, DIVZERO SHALL NOT be entered; a zero divisor SHALL run the full DIVON sequence.
REQ-028 Zero-divisor result without the macro: quotient 0xFFFFFFFF and remainder |dividend| before sign correction, ready_o after edge 34.

Structure
REQ-029 Shared package SHALL hold the DivState_t enum, the DivCnt_t 6-bit counter type and the DIV_STEPS=32 constant; existing Reg_t and DoubleReg_t SHALL be reused.
REQ-030 SHALL instantiate one combinational sub-module, div_step, performing one restoring compare/subtract/shift on a 33-bit partial remainder.

Verification
REQ-031 Unsigned 100/7: start held -> after edge 34 ready_o=1, result_o={32'd2, 32'd14}; start_i=0 -> ready_o=0 one edge later.
REQ-032 Signed -7/2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}; signed 0x80000000/-1 -> {0, 0x80000000}.
REQ-033 Divisor 0, macro defined -> ready_o after edge 2 with result 0; macro undefined -> ready_o after edge 34 with {dividend, 0xFFFFFFFF} for unsigned 5/0.
REQ-034 annul_i pulsed at cnt==10 -> IDLE next edge, ready_o never rises; a new 9/3 request is then accepted and returns {0, 3}.
REQ-035 rst=0 asserted asynchronously mid-DIVON -> outputs zero immediately without waiting for a clock; after release, 20/6 -> {2, 3}.
REQ-036 Operands changed each cycle during DIVON -> result matches the latched operands.
